seg7_scan_driver: RTL

//   Downstream display stage for the 4-bit add/subtract unit. Captures a

---
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Display stage for the 4-bit add/subtract unit. It captures a snapshot of
// {result, carry, subtract} on a load strobe. It then scans a 4-digit,
// common-anode seven-segment display, lighting one digit at a time.
// A new snapshot only reaches the visible digits at a frame boundary, so one
// scan never mixes old and new content.
//
// Parameters
//   REFRESH_DIV  clocks each digit stays lit (>= 1; 1 = advance every clk)
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   load      in   1-cycle strobe: sample result/carry/subtract this cycle
//   result    in   [3:0] adder/subtractor result
//   carry     in   adder carry-out (in subtract mode, 1 = no borrow)
//   subtract  in   operation mode of the sample (0 add, 1 subtract)
//   seg       out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   an        out  [3:0] active-low digit enables, an[0] = rightmost digit
//   dp        out  active-low decimal point, held off (1)
//   upd       out  1-cycle pulse after display was loaded from shadow
//
// Handshake: load is a plain strobe with no ready/back-pressure. Every cycle
// with load=1 is accepted unconditionally and overwrites the shadow sample.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] result,
  input  logic       carry,
  input  logic       subtract,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       upd
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [3:0] result;
    logic       carry;
    logic       subtract;
  } sample_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    idx;
  logic          pending;
  sample_t       shadow;
  sample_t       display;

  logic tc;
  logic boundary;

  assign tc       = (div_cnt == DIV_LAST);
  assign boundary = tc && (idx == 2'd3);

  // Active-low hex glyph table.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Content of the digit selected by d, given the displayed sample.
  function automatic logic [6:0] digit_glyph(input logic [1:0] d, input sample_t s);
    logic [6:0] g;
    case (d)
      2'd0: g = hex_glyph(s.result);
      2'd1: g = hex_glyph({3'b000, s.carry});
      // A subtraction that borrowed is a negative result, so show a minus sign.
      2'd2: g = (s.subtract && !s.carry) ? 7'h3F : 7'h7F;
      default: g = s.subtract ? 7'h12 : 7'h08;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] anode_sel(input logic [1:0] d);
    logic [3:0] a;
    a = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  // Divider, digit index, and capture/transfer of the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      pending <= 1'b0;
      shadow  <= '0;
      display <= '0;
      upd     <= 1'b0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      if (tc) idx <= idx + 2'd1;

      // The transfer uses the shadow value from before this edge. A load
      // on the boundary cycle therefore lands in shadow for the next frame.
      upd <= boundary && pending;
      if (boundary && pending) display <= shadow;

      if (load) begin
        shadow  <= '{result: result, carry: carry, subtract: subtract};
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs. These trail idx/display by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= anode_sel(idx);
      seg <= digit_glyph(idx, display);
      dp  <= 1'b1;
    end
  end

endmodule
